// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one multicycle memory between the I-cache and D-cache miss engines.
// Holds a grant for a whole burst and drains in-flight reads before handing memory to the other side.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic              i_wr,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              i_gnt,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_data_valid,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_data_valid,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_data_valid,
    output logic              proto_err
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DRAIN} state_t;

    state_t           state, state_nxt;
    logic             last_d, last_d_nxt;   // last owner: 1 = D-side, 0 = I-side
    logic [CNT_W-1:0] outstanding;
    logic             route_i, route_d;
    logic             rd_issue, valid_ok, stray_valid, overflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            last_d <= 1'b1;
        end else begin
            state  <= state_nxt;
            last_d <= last_d_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        last_d_nxt = last_d;
        case (state)
            IDLE: begin
                if (i_req && d_req)
                    state_nxt = last_d ? GNT_I : GNT_D;
                else if (i_req)
                    state_nxt = GNT_I;
                else if (d_req)
                    state_nxt = GNT_D;
            end
            GNT_I: begin
                if (!i_req) begin
                    last_d_nxt = 1'b0;
                    state_nxt  = (outstanding != '0) ? DRAIN : IDLE;
                end
            end
            GNT_D: begin
                if (!d_req) begin
                    last_d_nxt = 1'b1;
                    state_nxt  = (outstanding != '0) ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (outstanding == '0)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        i_gnt     = (state == GNT_I);
        d_gnt     = (state == GNT_D);
        route_i   = i_gnt || (state == DRAIN && !last_d);
        route_d   = d_gnt || (state == DRAIN &&  last_d);
        mem_enable = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (i_gnt) begin
            mem_enable = i_req;
            mem_wr     = i_wr;
            mem_addr   = i_addr;
            mem_wdata  = i_wdata;
        end else if (d_gnt) begin
            mem_enable = d_req;
            mem_wr     = d_wr;
            mem_addr   = d_addr;
            mem_wdata  = d_wdata;
        end
        // A valid with nothing outstanding is a protocol error and is not forwarded.
        valid_ok     = mem_data_valid && (outstanding != '0);
        stray_valid  = mem_data_valid && (outstanding == '0);
        rd_issue     = mem_enable && !mem_wr;
        overflow     = rd_issue && !valid_ok && (outstanding == '1);
        i_data_valid = valid_ok && route_i;
        d_data_valid = valid_ok && route_d;
        i_rdata      = i_data_valid ? mem_rdata : '0;
        d_rdata      = d_data_valid ? mem_rdata : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
            proto_err   <= 1'b0;
        end else begin
            if (stray_valid || overflow)
                proto_err <= 1'b1;
            if (rd_issue && !valid_ok && !overflow)
                outstanding <= outstanding + CNT_W'(1);
            else if (valid_ok && !rd_issue)
                outstanding <= outstanding - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a 4-cycle read-latency memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_wr, d_req, d_wr;
    logic [15:0] i_addr, i_wdata, d_addr, d_wdata;
    logic        i_gnt, d_gnt, i_data_valid, d_data_valid;
    logic [15:0] i_rdata, d_rdata;
    logic        mem_enable, mem_wr, mem_data_valid, proto_err;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    logic [3:0]  pv = '0;
    logic [15:0] pd [4];
    logic        inject;

    int n_checked = 0;
    int n_failed  = 0;
    int cyc = 0;
    int t0 = 0;
    int i_vcnt, d_vcnt, i_first, d_first;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_wr(i_wr), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_gnt(i_gnt), .i_rdata(i_rdata), .i_data_valid(i_data_valid),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rdata(d_rdata), .d_data_valid(d_data_valid),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_data_valid(mem_data_valid), .proto_err(proto_err)
    );

    // Memory model: read data = addr ^ 16'h5A5A, valid 4 cycles after issue; unaffected by rst.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        pv    <= {pv[2:0], mem_enable & ~mem_wr};
        pd[0] <= mem_addr ^ 16'h5A5A;
        pd[1] <= pd[0];
        pd[2] <= pd[1];
        pd[3] <= pd[2];
    end
    assign mem_data_valid = pv[3] | inject;
    assign mem_rdata      = inject ? 16'hDEAD : pd[3];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checked++;
        if (act !== exp) begin
            n_failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc - t0);
        end
    endtask

    always @(negedge clk) begin
        if (i_data_valid) begin
            i_vcnt++;
            if (i_first < 0) i_first = cyc - t0;
            check_eq("i_rdata", {16'h0, i_rdata}, {16'h0, pd[3]});
        end
        if (d_data_valid) begin
            d_vcnt++;
            if (d_first < 0) d_first = cyc - t0;
            check_eq("d_rdata", {16'h0, d_rdata}, {16'h0, pd[3]});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        i_vcnt  = 0;
        d_vcnt  = 0;
        i_first = -1;
        d_first = -1;
        t0      = cyc;
    endtask

    initial begin
        rst = 1'b1; inject = 1'b0;
        i_req = 1'b0; i_wr = 1'b0; i_addr = '0; i_wdata = '0;
        d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
        clr();
        step(); step();
        check_eq("rst_i_gnt", 32'(i_gnt), 0);
        check_eq("rst_d_gnt", 32'(d_gnt), 0);
        check_eq("rst_mem_en", 32'(mem_enable), 0);
        check_eq("rst_err", 32'(proto_err), 0);
        rst = 1'b0;
        step();

        // 1) I-only read burst
        clr();
        i_req = 1'b1; i_wr = 1'b0; i_addr = 16'h0010;
        #1;
        check_eq("t1_c0_gnt", 32'(i_gnt), 0);
        check_eq("t1_c0_en", 32'(mem_enable), 0);
        for (int k = 0; k < 8; k++) begin
            step();
            i_addr = 16'h0010 + 16'(k);
            #1;
            if (k == 0) begin
                check_eq("t1_i_gnt", 32'(i_gnt), 1);
                check_eq("t1_d_gnt", 32'(d_gnt), 0);
            end
            check_eq("t1_mem_en", 32'(mem_enable), 1);
            check_eq("t1_mem_addr", 32'(mem_addr), 32'h0010 + 32'(k));
        end
        step();
        i_req = 1'b0;
        repeat (10) step();
        check_eq("t1_i_vcnt", 32'(i_vcnt), 8);
        check_eq("t1_i_first", 32'(i_first), 5);
        check_eq("t1_d_vcnt", 32'(d_vcnt), 0);
        check_eq("t1_err", 32'(proto_err), 0);

        // 2) tie from reset, turnaround, alternating tie
        rst = 1'b1;
        step();
        rst = 1'b0;
        clr();
        i_req = 1'b1; d_req = 1'b1; i_wr = 1'b1; d_wr = 1'b1;
        i_addr = 16'h0020; d_addr = 16'h0040;
        #1;
        check_eq("t2_c0_i", 32'(i_gnt), 0);
        check_eq("t2_c0_d", 32'(d_gnt), 0);
        step();
        check_eq("t2_c1_i", 32'(i_gnt), 1);
        check_eq("t2_c1_d", 32'(d_gnt), 0);
        check_eq("t2_c1_wr", 32'(mem_wr), 1);
        check_eq("t2_c1_addr", 32'(mem_addr), 32'h0020);
        step();
        step();
        i_req = 1'b0;
        #1;
        check_eq("t2_c3_i", 32'(i_gnt), 1);
        check_eq("t2_c3_en", 32'(mem_enable), 0);
        step();
        check_eq("t2_c4_i", 32'(i_gnt), 0);
        check_eq("t2_c4_d", 32'(d_gnt), 0);
        check_eq("t2_c4_addr", 32'(mem_addr), 0);
        check_eq("t2_c4_wr", 32'(mem_wr), 0);
        step();
        check_eq("t2_c5_d", 32'(d_gnt), 1);
        check_eq("t2_c5_addr", 32'(mem_addr), 32'h0040);
        check_eq("t2_c5_en", 32'(mem_enable), 1);
        step();
        d_req = 1'b0; i_req = 1'b1;
        #1;
        check_eq("t2_c6_d", 32'(d_gnt), 1);
        check_eq("t2_c6_i", 32'(i_gnt), 0);
        step();
        d_req = 1'b1;
        #1;
        check_eq("t2_c7_i", 32'(i_gnt), 0);
        check_eq("t2_c7_d", 32'(d_gnt), 0);
        step();
        check_eq("t2_c8_i", 32'(i_gnt), 1);
        check_eq("t2_c8_d", 32'(d_gnt), 0);
        step();
        i_req = 1'b0; d_req = 1'b0;
        step(); step();

        // 3) D reads then drop with I pending: drain before handover
        clr();
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0200;
        for (int k = 0; k < 4; k++) begin
            step();
            d_addr = 16'h0200 + 16'(k);
            if (k == 1) begin
                i_req = 1'b1; i_wr = 1'b1;
            end
            #1;
            if (k == 0) check_eq("t3_d_gnt", 32'(d_gnt), 1);
        end
        step();
        d_req = 1'b0;
        #1;
        check_eq("t3_c5_d", 32'(d_gnt), 1);
        check_eq("t3_c5_en", 32'(mem_enable), 0);
        for (int k = 6; k <= 10; k++) begin
            step();
            check_eq("t3_i_wait", 32'(i_gnt), 0);
            if (k == 6) check_eq("t3_c6_d", 32'(d_gnt), 0);
        end
        step();
        check_eq("t3_c11_i", 32'(i_gnt), 1);
        check_eq("t3_c11_wr", 32'(mem_wr), 1);
        check_eq("t3_d_vcnt", 32'(d_vcnt), 4);
        check_eq("t3_d_first", 32'(d_first), 5);
        check_eq("t3_i_vcnt", 32'(i_vcnt), 0);
        i_req = 1'b0;
        step(); step();

        // 4) D write burst (last owner I, so D wins the tie), writes not counted
        clr();
        d_req = 1'b1; d_wr = 1'b1; i_req = 1'b1; i_wr = 1'b0; i_addr = 16'h0080;
        #1;
        check_eq("t4_c0_d", 32'(d_gnt), 0);
        for (int k = 0; k < 8; k++) begin
            step();
            d_addr  = 16'h0300 + 16'(k);
            d_wdata = 16'hBEE0 + 16'(k);
            #1;
            if (k == 0) begin
                check_eq("t4_d_gnt", 32'(d_gnt), 1);
                check_eq("t4_i_gnt", 32'(i_gnt), 0);
            end
            check_eq("t4_wr", 32'(mem_wr), 1);
            check_eq("t4_wdata", 32'(mem_wdata), 32'hBEE0 + 32'(k));
        end
        step();
        d_req = 1'b0;
        step();
        check_eq("t4_c10_i", 32'(i_gnt), 0);
        check_eq("t4_c10_d", 32'(d_gnt), 0);
        step();
        check_eq("t4_c11_i", 32'(i_gnt), 1);
        check_eq("t4_c11_en", 32'(mem_enable), 1);
        check_eq("t4_c11_wr", 32'(mem_wr), 0);
        step();
        i_req = 1'b0;
        repeat (8) step();
        check_eq("t4_i_vcnt", 32'(i_vcnt), 1);
        check_eq("t4_i_first", 32'(i_first), 15);
        check_eq("t4_d_vcnt", 32'(d_vcnt), 0);
        check_eq("t4_err", 32'(proto_err), 0);

        // 5) stray data_valid with nothing outstanding
        inject = 1'b1;
        #1;
        check_eq("t5_i_dv", 32'(i_data_valid), 0);
        check_eq("t5_d_dv", 32'(d_data_valid), 0);
        check_eq("t5_i_rdata", 32'(i_rdata), 0);
        check_eq("t5_d_rdata", 32'(d_rdata), 0);
        check_eq("t5_err_pre", 32'(proto_err), 0);
        step();
        inject = 1'b0;
        #1;
        check_eq("t5_err_set", 32'(proto_err), 1);
        repeat (3) step();
        check_eq("t5_err_sticky", 32'(proto_err), 1);

        // 6) reset in the middle of a read burst
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check_eq("t6_err_clr", 32'(proto_err), 0);
        clr();
        i_req = 1'b1; i_wr = 1'b0; i_addr = 16'h0400;
        for (int k = 0; k < 3; k++) begin
            step();
            i_addr = 16'h0400 + 16'(k);
        end
        step();
        rst = 1'b1;
        #1;
        check_eq("t6_rst_i", 32'(i_gnt), 0);
        check_eq("t6_rst_d", 32'(d_gnt), 0);
        check_eq("t6_rst_en", 32'(mem_enable), 0);
        step();
        rst = 1'b0; i_req = 1'b0;
        step(); step(); step();
        check_eq("t6_stale_err", 32'(proto_err), 1);
        check_eq("t6_stale_vcnt", 32'(i_vcnt), 0);
        i_req = 1'b1; i_addr = 16'h0500;
        step();
        check_eq("t6_regnt", 32'(i_gnt), 1);
        check_eq("t6_reen", 32'(mem_enable), 1);
        step();
        i_req = 1'b0;
        repeat (6) step();
        check_eq("t6_i_vcnt", 32'(i_vcnt), 1);
        check_eq("t6_i_first", 32'(i_first), 13);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checked, n_failed);
        $finish;
    end

endmodule
